pixel_dispatcher: RTL and testbench



---
 rtl/pixel_dispatcher.sv | 188 ++++++++++++++++++
 tb/tb_pixel_dispatcher.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_dispatcher.sv
// Dispatches raster pixel coordinates round-robin to a pool of raymarcher workers
// and retires their finished colours, one per cycle, into the frame-buffer write port.
module pixel_dispatcher #(
  parameter int WIDTH       = 1280,
  parameter int HEIGHT      = 720,
  parameter int NUM_WORKERS = 2,
  parameter int COLOR_W     = 24,
  localparam int XW = $clog2(WIDTH),
  localparam int YW = $clog2(HEIGHT),
  localparam int AW = $clog2(WIDTH * HEIGHT)
) (
  input  logic                           clk_in,
  input  logic                           rst_n_in,
  input  logic                           enable_in,
  input  logic [NUM_WORKERS-1:0]         worker_ready_in,
  output logic [NUM_WORKERS-1:0]         worker_start_out,
  output logic [XW-1:0]                  pixel_x_out,
  output logic [YW-1:0]                  pixel_y_out,
  output logic [31:0]                    frame_count_out,
  input  logic [NUM_WORKERS-1:0]         result_valid_in,
  input  logic [NUM_WORKERS*XW-1:0]      result_x_in,
  input  logic [NUM_WORKERS*YW-1:0]      result_y_in,
  input  logic [NUM_WORKERS*COLOR_W-1:0] result_color_in,
  output logic [NUM_WORKERS-1:0]         result_ack_out,
  output logic                           fb_we_out,
  output logic [AW-1:0]                  fb_addr_out,
  output logic [COLOR_W-1:0]             fb_data_out,
  output logic                           frame_done_out,
  output logic                           error_out
);

  localparam int PW        = (NUM_WORKERS > 1) ? $clog2(NUM_WORKERS) : 1;
  localparam int FRAME_PIX = WIDTH * HEIGHT;

  logic [NUM_WORKERS-1:0] busy_reg;
  logic [PW-1:0]          issue_ptr_reg;
  logic [PW-1:0]          ret_ptr_reg;
  logic [XW-1:0]          cur_x_reg;
  logic [YW-1:0]          cur_y_reg;
  logic [31:0]            frame_cnt_reg;
  logic [AW-1:0]          retire_cnt_reg;
  logic [NUM_WORKERS-1:0] start_reg;
  logic [XW-1:0]          px_reg;
  logic [YW-1:0]          py_reg;
  logic [NUM_WORKERS-1:0] ack_reg;
  logic                   we_reg;
  logic [AW-1:0]          addr_reg;
  logic [COLOR_W-1:0]     data_reg;
  logic                   done_reg;
  logic                   err_reg;

  logic [XW-1:0]      res_x     [NUM_WORKERS];
  logic [YW-1:0]      res_y     [NUM_WORKERS];
  logic [COLOR_W-1:0] res_color [NUM_WORKERS];

  generate
    for (genvar gi = 0; gi < NUM_WORKERS; gi++) begin : g_unpack
      assign res_x[gi]     = result_x_in[gi*XW +: XW];
      assign res_y[gi]     = result_y_in[gi*YW +: YW];
      assign res_color[gi] = result_color_in[gi*COLOR_W +: COLOR_W];
    end
  endgenerate

  function automatic logic [PW-1:0] rr_index(input logic [PW-1:0] ptr, input int k);
    return PW'((int'(ptr) + k) % NUM_WORKERS);
  endfunction

  logic [NUM_WORKERS-1:0] eligible;
  logic [NUM_WORKERS-1:0] ret_cand;
  logic                   disp_found;
  logic [PW-1:0]          disp_idx;
  logic                   ret_found;
  logic [PW-1:0]          ret_idx;

  assign eligible = worker_ready_in & ~busy_reg;
  // The worker acked this cycle still shows valid; masking it prevents a double retire.
  assign ret_cand = result_valid_in & ~ack_reg;

  always_comb begin
    disp_found = 1'b0;
    disp_idx   = '0;
    for (int k = 0; k < NUM_WORKERS; k++) begin
      if (!disp_found && eligible[rr_index(issue_ptr_reg, k)]) begin
        disp_found = 1'b1;
        disp_idx   = rr_index(issue_ptr_reg, k);
      end
    end
  end

  always_comb begin
    ret_found = 1'b0;
    ret_idx   = '0;
    for (int k = 0; k < NUM_WORKERS; k++) begin
      if (!ret_found && ret_cand[rr_index(ret_ptr_reg, k)]) begin
        ret_found = 1'b1;
        ret_idx   = rr_index(ret_ptr_reg, k);
      end
    end
  end

  logic                   disp_go;
  logic [NUM_WORKERS-1:0] disp_onehot;
  logic [NUM_WORKERS-1:0] ret_onehot;
  logic [XW-1:0]          ret_x;
  logic [YW-1:0]          ret_y;
  logic                   ret_in_range;
  logic [AW-1:0]          ret_addr;

  assign disp_go      = enable_in && disp_found;
  assign disp_onehot  = disp_go ? (NUM_WORKERS'(1) << disp_idx) : '0;
  assign ret_onehot   = ret_found ? (NUM_WORKERS'(1) << ret_idx) : '0;
  assign ret_x        = res_x[ret_idx];
  assign ret_y        = res_y[ret_idx];
  assign ret_in_range = (int'(ret_x) < WIDTH) && (int'(ret_y) < HEIGHT);
  assign ret_addr     = AW'(ret_y) * AW'(WIDTH) + AW'(ret_x);

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      busy_reg       <= '0;
      issue_ptr_reg  <= '0;
      ret_ptr_reg    <= '0;
      cur_x_reg      <= '0;
      cur_y_reg      <= '0;
      frame_cnt_reg  <= '0;
      retire_cnt_reg <= '0;
      start_reg      <= '0;
      px_reg         <= '0;
      py_reg         <= '0;
      ack_reg        <= '0;
      we_reg         <= 1'b0;
      addr_reg       <= '0;
      data_reg       <= '0;
      done_reg       <= 1'b0;
      err_reg        <= 1'b0;
    end else begin
      start_reg <= disp_onehot;
      ack_reg   <= ret_onehot;
      we_reg    <= ret_found && ret_in_range;
      done_reg  <= 1'b0;
      busy_reg  <= (busy_reg & ~ret_onehot) | disp_onehot;

      if (disp_go) begin
        px_reg        <= cur_x_reg;
        py_reg        <= cur_y_reg;
        issue_ptr_reg <= rr_index(disp_idx, 1);
        if (cur_x_reg == XW'(WIDTH - 1)) begin
          cur_x_reg <= '0;
          if (cur_y_reg == YW'(HEIGHT - 1)) begin
            cur_y_reg     <= '0;
            frame_cnt_reg <= frame_cnt_reg + 32'd1;
          end else begin
            cur_y_reg <= cur_y_reg + YW'(1);
          end
        end else begin
          cur_x_reg <= cur_x_reg + XW'(1);
        end
      end

      // Out-of-range results still count toward frame completion so the frame can close.
      if (ret_found) begin
        addr_reg    <= ret_addr;
        data_reg    <= res_color[ret_idx];
        ret_ptr_reg <= rr_index(ret_idx, 1);
        if (!ret_in_range) begin
          err_reg <= 1'b1;
        end
        if (retire_cnt_reg == AW'(FRAME_PIX - 1)) begin
          retire_cnt_reg <= '0;
          done_reg       <= 1'b1;
        end else begin
          retire_cnt_reg <= retire_cnt_reg + AW'(1);
        end
      end
    end
  end

  assign worker_start_out = start_reg;
  assign pixel_x_out      = px_reg;
  assign pixel_y_out      = py_reg;
  assign frame_count_out  = frame_cnt_reg;
  assign result_ack_out   = ack_reg;
  assign fb_we_out        = we_reg;
  assign fb_addr_out      = addr_reg;
  assign fb_data_out      = data_reg;
  assign frame_done_out   = done_reg;
  assign error_out        = err_reg;

endmodule

// File: tb/tb_pixel_dispatcher.sv
// Bench for pixel_dispatcher: behavioural worker pool plus a write scoreboard.
// A 5x3 frame keeps x=5 and y=3 representable so out-of-range results can be driven.
module tb_pixel_dispatcher;
  localparam int W = 5;
  localparam int H = 3;
  localparam int N = 2;
  localparam int CW = 24;
  localparam int XW = 3;
  localparam int YW = 2;
  localparam int AW = 4;
  localparam int FRAME = W * H;

  logic              clk_in = 1'b0;
  logic              rst_n_in;
  logic              enable_in;
  logic [N-1:0]      worker_ready_in;
  logic [N-1:0]      worker_start_out;
  logic [XW-1:0]     pixel_x_out;
  logic [YW-1:0]     pixel_y_out;
  logic [31:0]       frame_count_out;
  logic [N-1:0]      result_valid_in;
  logic [N*XW-1:0]   result_x_in;
  logic [N*YW-1:0]   result_y_in;
  logic [N*CW-1:0]   result_color_in;
  logic [N-1:0]      result_ack_out;
  logic              fb_we_out;
  logic [AW-1:0]     fb_addr_out;
  logic [CW-1:0]     fb_data_out;
  logic              frame_done_out;
  logic              error_out;

  pixel_dispatcher #(.WIDTH(W), .HEIGHT(H), .NUM_WORKERS(N), .COLOR_W(CW)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .enable_in(enable_in),
    .worker_ready_in(worker_ready_in), .worker_start_out(worker_start_out),
    .pixel_x_out(pixel_x_out), .pixel_y_out(pixel_y_out), .frame_count_out(frame_count_out),
    .result_valid_in(result_valid_in), .result_x_in(result_x_in), .result_y_in(result_y_in),
    .result_color_in(result_color_in), .result_ack_out(result_ack_out),
    .fb_we_out(fb_we_out), .fb_addr_out(fb_addr_out), .fb_data_out(fb_data_out),
    .frame_done_out(frame_done_out), .error_out(error_out)
  );

  always #5 clk_in = ~clk_in;

  int errors = 0;
  int checks = 0;
  int lat [N];
  bit job [N];
  bit pres [N];
  int cd [N];
  int jx [N];
  int jy [N];
  int ex, ey, starts, acks, done_cnt, last_w, last_x, last_y;
  logic [31:0] exp_frames;
  int wr_count [FRAME];
  logic [AW+CW-1:0] sb_q [$];

  function automatic logic [CW-1:0] color_of(input int x, input int y);
    return CW'(x * 4099 + y * 131 + 24'h3C0000);
  endfunction

  task automatic drive_worker(input int w);
    result_valid_in[w]            = pres[w];
    result_x_in[w*XW +: XW]       = XW'(jx[w]);
    result_y_in[w*YW +: YW]       = YW'(jy[w]);
    result_color_in[w*CW +: CW]   = color_of(jx[w], jy[w]);
  endtask

  task automatic present(input int w, input int x, input int y);
    job[w] = 1; pres[w] = 1; jx[w] = x; jy[w] = y;
    drive_worker(w);
    if (x < W && y < H) sb_q.push_back({AW'(y * W + x), color_of(x, y)});
  endtask

  task automatic clear_model();
    for (int i = 0; i < N; i++) begin
      job[i] = 0; pres[i] = 0; cd[i] = 0; jx[i] = 0; jy[i] = 0; lat[i] = 3;
    end
    result_valid_in = '0; result_x_in = '0; result_y_in = '0; result_color_in = '0;
    ex = 0; ey = 0; exp_frames = '0; starts = 0; acks = 0; done_cnt = 0;
    last_w = -1; last_x = -1; last_y = -1;
    for (int i = 0; i < FRAME; i++) wr_count[i] = 0;
    sb_q.delete();
  endtask

  // One clock of the worker pool: observe registered outputs, score them, advance workers.
  task automatic step();
    int w;
    bit exp_done;
    bit found;
    @(negedge clk_in);
    if (worker_start_out != '0) begin
      checks++;
      if ($countones(worker_start_out) != 1) begin
        errors++; $display("FAIL start_onehot: got %b, need one bit set", worker_start_out);
      end
      w = 0;
      for (int i = 0; i < N; i++) if (worker_start_out[i]) w = i;
      checks++;
      if (pixel_x_out !== XW'(ex) || pixel_y_out !== YW'(ey)) begin
        errors++; $display("FAIL start_xy: got (%0d,%0d) need (%0d,%0d)", pixel_x_out, pixel_y_out, ex, ey);
      end
      checks++;
      if (job[w]) begin
        errors++; $display("FAIL start_busy: worker %0d started while holding a job", w);
      end
      job[w] = 1; pres[w] = 0; cd[w] = lat[w]; jx[w] = ex; jy[w] = ey;
      last_w = w; last_x = int'(pixel_x_out); last_y = int'(pixel_y_out); starts++;
      if (ex == W - 1) begin
        ex = 0;
        if (ey == H - 1) begin ey = 0; exp_frames++; end else ey++;
      end else ex++;
      checks++;
      if (frame_count_out !== exp_frames) begin
        errors++; $display("FAIL frame_count: got %0d need %0d", frame_count_out, exp_frames);
      end
    end
    exp_done = 0;
    if (result_ack_out != '0) begin
      checks++;
      if ($countones(result_ack_out) != 1) begin
        errors++; $display("FAIL ack_onehot: got %b, need one bit set", result_ack_out);
      end
      w = 0;
      for (int i = 0; i < N; i++) if (result_ack_out[i]) w = i;
      checks++;
      if (!pres[w]) begin
        errors++; $display("FAIL ack_unexpected: worker %0d acked with no result presented", w);
      end
      pres[w] = 0; job[w] = 0; drive_worker(w); acks++;
      exp_done = (acks % FRAME == 0);
    end
    checks++;
    if (frame_done_out !== exp_done) begin
      errors++; $display("FAIL frame_done: got %b need %b (acks=%0d)", frame_done_out, exp_done, acks);
    end
    if (frame_done_out === 1'b1) done_cnt++;
    if (fb_we_out === 1'b1) begin
      found = 0;
      for (int i = 0; i < sb_q.size() && !found; i++) begin
        if (sb_q[i][AW+CW-1:CW] == fb_addr_out) begin
          found = 1;
          checks++;
          if (fb_data_out !== sb_q[i][CW-1:0]) begin
            errors++; $display("FAIL fb_data: addr %0d got %h need %h", fb_addr_out, fb_data_out, sb_q[i][CW-1:0]);
          end
          sb_q.delete(i);
        end
      end
      checks++;
      if (!found) begin
        errors++; $display("FAIL fb_write: got write to addr %0d, need none pending there", fb_addr_out);
      end else if (int'(fb_addr_out) < FRAME) wr_count[fb_addr_out]++;
    end
    for (int i = 0; i < N; i++) begin
      if (job[i] && !pres[i]) begin
        if (cd[i] > 0) cd[i]--;
        if (cd[i] == 0) present(i, jx[i], jy[i]);
      end
    end
  endtask

  task automatic reset_dut();
    rst_n_in = 1'b0; enable_in = 1'b0;
    clear_model();
    @(negedge clk_in);
    checks += 10;
    if (worker_start_out !== '0) begin errors++; $display("FAIL rst_start: got %b need 0", worker_start_out); end
    if (pixel_x_out !== '0) begin errors++; $display("FAIL rst_px: got %0d need 0", pixel_x_out); end
    if (pixel_y_out !== '0) begin errors++; $display("FAIL rst_py: got %0d need 0", pixel_y_out); end
    if (frame_count_out !== '0) begin errors++; $display("FAIL rst_frames: got %0d need 0", frame_count_out); end
    if (result_ack_out !== '0) begin errors++; $display("FAIL rst_ack: got %b need 0", result_ack_out); end
    if (fb_we_out !== 1'b0) begin errors++; $display("FAIL rst_we: got %b need 0", fb_we_out); end
    if (fb_addr_out !== '0) begin errors++; $display("FAIL rst_addr: got %0d need 0", fb_addr_out); end
    if (fb_data_out !== '0) begin errors++; $display("FAIL rst_data: got %h need 0", fb_data_out); end
    if (frame_done_out !== 1'b0) begin errors++; $display("FAIL rst_done: got %b need 0", frame_done_out); end
    if (error_out !== 1'b0) begin errors++; $display("FAIL rst_error: got %b need 0", error_out); end
    rst_n_in = 1'b1;
  endtask

  task automatic run_starts(input int target);
    int c = 0;
    while (starts < target && c < 400) begin step(); c++; end
    enable_in = 1'b0;
    checks++;
    if (starts < target) begin
      errors++; $display("FAIL start_timeout: got %0d starts need %0d", starts, target);
    end
  endtask

  task automatic drain();
    int c = 0;
    bit busy_any = 1;
    while (busy_any && c < 200) begin
      step(); c++;
      busy_any = (sb_q.size() != 0);
      for (int i = 0; i < N; i++) if (job[i]) busy_any = 1;
    end
    checks++;
    if (busy_any) begin
      errors++; $display("FAIL drain_timeout: got %0d writes still pending, need 0", sb_q.size());
    end
  endtask

  task automatic check_frame_written(input string tag);
    int bad = 0;
    for (int i = 0; i < FRAME; i++) if (wr_count[i] != 1) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL %s_writes: got %0d addresses not written exactly once, need 0", tag, bad); end
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL %s_done_count: got %0d pulses need 1", tag, done_cnt); end
    checks++;
    if (frame_count_out !== 32'd1) begin errors++; $display("FAIL %s_frames: got %0d need 1", tag, frame_count_out); end
  endtask

  task automatic test_reset();
    reset_dut();
    $display("test_reset done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_full_frame();
    int c = 0;
    int prev;
    reset_dut();
    lat[0] = 3; lat[1] = 3;
    enable_in = 1'b1;
    while (starts < FRAME && c < 400) begin
      prev = starts;
      step(); c++;
      if (starts != prev) begin
        checks++;
        if (last_w != (starts - 1) % 2) begin
          errors++; $display("FAIL alternate: start %0d got worker %0d need %0d", starts, last_w, (starts - 1) % 2);
        end
      end
      if (starts == FRAME) enable_in = 1'b0;
    end
    enable_in = 1'b0;
    drain();
    check_frame_written("frame");
    checks++;
    if (error_out !== 1'b0) begin errors++; $display("FAIL frame_error: got %b need 0", error_out); end
    $display("test_full_frame done: starts=%0d acks=%0d", starts, acks);
  endtask

  task automatic test_out_of_order();
    reset_dut();
    lat[0] = 2; lat[1] = 10;
    enable_in = 1'b1;
    run_starts(FRAME);
    drain();
    check_frame_written("ooo");
    $display("test_out_of_order done: starts=%0d acks=%0d", starts, acks);
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] first;
    reset_dut();
    present(0, 1, 0);
    present(1, 2, 1);
    step();
    first = result_ack_out;
    checks++;
    if ($countones(first) != 1) begin errors++; $display("FAIL b2b_first: got %b need one ack", first); end
    step();
    checks++;
    if ($countones(result_ack_out) != 1 || (result_ack_out & first) != '0) begin
      errors++; $display("FAIL b2b_second: got %b need the other worker (first %b)", result_ack_out, first);
    end
    step();
    checks++;
    if (result_ack_out !== '0) begin errors++; $display("FAIL b2b_idle: got %b need 0", result_ack_out); end
    checks++;
    if (wr_count[1] != 1 || wr_count[7] != 1 || sb_q.size() != 0) begin
      errors++; $display("FAIL b2b_writes: got counts %0d/%0d pending %0d, need 1/1/0", wr_count[1], wr_count[7], sb_q.size());
    end
    $display("test_back_to_back done: acks=%0d", acks);
  endtask

  task automatic test_error();
    reset_dut();
    present(0, 5, 0);
    step();
    checks++;
    if (result_ack_out !== 2'b01 || fb_we_out !== 1'b0 || error_out !== 1'b1) begin
      errors++; $display("FAIL err_x: got ack=%b we=%b err=%b need 01/0/1", result_ack_out, fb_we_out, error_out);
    end
    present(1, 1, 3);
    step();
    checks++;
    if (result_ack_out !== 2'b10 || fb_we_out !== 1'b0) begin
      errors++; $display("FAIL err_y: got ack=%b we=%b need 10/0", result_ack_out, fb_we_out);
    end
    repeat (3) step();
    checks++;
    if (error_out !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b need 1", error_out); end
    $display("test_error done: acks=%0d", acks);
  endtask

  task automatic test_enable();
    int c = 0;
    reset_dut();
    lat[0] = 4; lat[1] = 4;
    enable_in = 1'b1;
    run_starts(3);
    repeat (10) step();
    checks++;
    if (starts != 3) begin errors++; $display("FAIL en_hold: got %0d starts need 3", starts); end
    checks++;
    if (acks != 3) begin errors++; $display("FAIL en_retire: got %0d acks need 3", acks); end
    enable_in = 1'b1;
    while (starts < 4 && c < 50) begin step(); c++; end
    enable_in = 1'b0;
    checks++;
    if (last_x != 3 || last_y != 0 || starts != 4) begin
      errors++; $display("FAIL en_resume: got (%0d,%0d) starts=%0d need (3,0) starts=4", last_x, last_y, starts);
    end
    drain();
    $display("test_enable done: starts=%0d acks=%0d", starts, acks);
  endtask

  task automatic test_reset_mid();
    int c = 0;
    reset_dut();
    lat[0] = 5; lat[1] = 5;
    enable_in = 1'b1;
    run_starts(4);
    enable_in = 1'b1;
    step();
    reset_dut();
    enable_in = 1'b1;
    while (starts < 1 && c < 50) begin step(); c++; end
    enable_in = 1'b0;
    checks++;
    if (last_w != 0 || last_x != 0 || last_y != 0) begin
      errors++; $display("FAIL rst_mid_first: got worker %0d (%0d,%0d) need worker 0 (0,0)", last_w, last_x, last_y);
    end
    drain();
    $display("test_reset_mid done: starts=%0d acks=%0d", starts, acks);
  endtask

  initial begin
    rst_n_in = 1'b0;
    enable_in = 1'b0;
    worker_ready_in = '1;
    clear_model();
    test_reset();
    test_full_frame();
    test_out_of_order();
    test_back_to_back();
    test_error();
    test_enable();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
